// File: rtl/execute_pkg.sv
// execute_pkg: shared ALUOp/funct codes, ALU operation enum and the MULT
// sequencer state enum for the MIPS EX stage.
package execute_pkg;

  // ALUOp field of id_ex_execute, as produced by decode
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct codes understood by the ALU control
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_MUL,
    ALU_ZERO
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mul_state_e;

  // ALU control: ALUOp selects a fixed op, or defers to the funct field.
  // Unknown funct codes produce a zero result but still pass control through.
  function automatic alu_op_e alu_ctl(input logic [1:0] aluop, input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ZERO;
    case (aluop)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_OR:  op = ALU_OR;
      default: begin
        case (funct)
          FUNCT_ADD:  op = ALU_ADD;
          FUNCT_SUB:  op = ALU_SUB;
          FUNCT_AND:  op = ALU_AND;
          FUNCT_OR:   op = ALU_OR;
          FUNCT_SLT:  op = ALU_SLT;
          FUNCT_MULT: op = ALU_MUL;
          default:    op = ALU_ZERO;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/execute_if.sv
// execute_if: ID/EX latch fields into the EX stage and EX/MEM latch fields
// out of it. The slave modport is the EX stage; the master is its environment.
// Optional macro EXECUTE_FWD_EN adds the rs specifier and MEM/WB writeback
// signals used for operand forwarding.
interface execute_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  logic [1:0]            id_ex_wb;
  logic [2:0]            id_ex_mem;
  logic [3:0]            id_ex_execute;
  logic [DATA_W-1:0]     id_ex_npc;
  logic [DATA_W-1:0]     id_ex_readdat1;
  logic [DATA_W-1:0]     id_ex_readdat2;
  logic [DATA_W-1:0]     id_ex_sign_ext;
  logic [REG_ADDR_W-1:0] id_ex_instr_bits_20_16;
  logic [REG_ADDR_W-1:0] id_ex_instr_bits_15_11;
`ifdef EXECUTE_FWD_EN
  logic [REG_ADDR_W-1:0] id_ex_instr_bits_25_21;
  logic                  mem_wb_reg_write;
  logic [REG_ADDR_W-1:0] mem_wb_write_reg;
  logic [DATA_W-1:0]     mem_wb_write_data;
`endif

  logic                  ex_stall;
  logic [1:0]            ex_mem_wb;
  logic [2:0]            ex_mem_m;
  logic [DATA_W-1:0]     ex_mem_btgt;
  logic                  ex_mem_zero;
  logic [DATA_W-1:0]     ex_mem_alu_result;
  logic [DATA_W-1:0]     ex_mem_rdata2;
  logic [REG_ADDR_W-1:0] ex_mem_write_reg;

  modport slave (
`ifdef EXECUTE_FWD_EN
    input  id_ex_instr_bits_25_21, mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
`endif
    input  id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc, id_ex_readdat1,
           id_ex_readdat2, id_ex_sign_ext, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
    output ex_stall, ex_mem_wb, ex_mem_m, ex_mem_btgt, ex_mem_zero,
           ex_mem_alu_result, ex_mem_rdata2, ex_mem_write_reg
  );

  modport master (
`ifdef EXECUTE_FWD_EN
    output id_ex_instr_bits_25_21, mem_wb_reg_write, mem_wb_write_reg, mem_wb_write_data,
`endif
    output id_ex_wb, id_ex_mem, id_ex_execute, id_ex_npc, id_ex_readdat1,
           id_ex_readdat2, id_ex_sign_ext, id_ex_instr_bits_20_16, id_ex_instr_bits_15_11,
    input  ex_stall, ex_mem_wb, ex_mem_m, ex_mem_btgt, ex_mem_zero,
           ex_mem_alu_result, ex_mem_rdata2, ex_mem_write_reg
  );

endinterface

// File: rtl/execute_mul_iter.sv
// mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// IDLE loads operands on start, BUSY runs DATA_W iterations, DONE presents
// the low DATA_W bits of the product for exactly one cycle.
module mul_iter
  import execute_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int               CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;

  // Sequencer state and datapath registers; reset aborts any multiply in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Next state: load in IDLE, add-and-shift in BUSY, single-cycle DONE.
  // Bits shifted out of the multiplicand only affect the discarded HI word.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/execute.sv
// execute: EX stage of the 5-stage MIPS pipeline. ALU control, ALU, branch
// target adder, destination select and the EX/MEM latch, plus an iterative
// MULT unit that stalls upstream while it runs.
// Optional macro EXECUTE_FWD_EN enables EX/MEM and MEM/WB operand forwarding.
module execute
  import execute_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic      clk,
  input logic      rst,
  execute_if.slave bus
);

  logic                  reg_dst;
  logic [1:0]            aluop;
  logic                  alu_src;
  logic [5:0]            funct;
  alu_op_e               alu_op;
  logic                  is_mult;

  logic [DATA_W-1:0]     opnd_a;
  logic [DATA_W-1:0]     opnd_b;
  logic [DATA_W-1:0]     alu_b;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     result_sel;
  logic [DATA_W-1:0]     btgt;
  logic [REG_ADDR_W-1:0] write_reg;

  logic                  mul_busy;
  logic                  mul_done;
  logic [DATA_W-1:0]     mul_product;
  logic                  stall;

  logic [1:0]            ex_mem_wb_q, ex_mem_wb_d;
  logic [2:0]            ex_mem_m_q, ex_mem_m_d;
  logic [DATA_W-1:0]     ex_mem_btgt_q, ex_mem_btgt_d;
  logic                  ex_mem_zero_q, ex_mem_zero_d;
  logic [DATA_W-1:0]     ex_mem_alu_result_q, ex_mem_alu_result_d;
  logic [DATA_W-1:0]     ex_mem_rdata2_q, ex_mem_rdata2_d;
  logic [REG_ADDR_W-1:0] ex_mem_write_reg_q, ex_mem_write_reg_d;

  assign reg_dst = bus.id_ex_execute[3];
  assign aluop   = bus.id_ex_execute[2:1];
  assign alu_src = bus.id_ex_execute[0];
  assign funct   = bus.id_ex_sign_ext[5:0];
  assign alu_op  = alu_ctl(aluop, funct);
  assign is_mult = (alu_op == ALU_MUL);

`ifdef EXECUTE_FWD_EN
  logic ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

  // A result writing r0 is never forwarded; the older MEM/WB value loses to EX/MEM
  assign ex_hit_a = ex_mem_wb_q[1] && (ex_mem_write_reg_q != '0) &&
                    (ex_mem_write_reg_q == bus.id_ex_instr_bits_25_21);
  assign ex_hit_b = ex_mem_wb_q[1] && (ex_mem_write_reg_q != '0) &&
                    (ex_mem_write_reg_q == bus.id_ex_instr_bits_20_16);
  assign wb_hit_a = bus.mem_wb_reg_write && (bus.mem_wb_write_reg != '0) &&
                    (bus.mem_wb_write_reg == bus.id_ex_instr_bits_25_21);
  assign wb_hit_b = bus.mem_wb_reg_write && (bus.mem_wb_write_reg != '0) &&
                    (bus.mem_wb_write_reg == bus.id_ex_instr_bits_20_16);

  // Forwarding muxes for the rs and rt operands
  always_comb begin
    opnd_a = bus.id_ex_readdat1;
    opnd_b = bus.id_ex_readdat2;
    if (ex_hit_a) begin
      opnd_a = ex_mem_alu_result_q;
    end else if (wb_hit_a) begin
      opnd_a = bus.mem_wb_write_data;
    end
    if (ex_hit_b) begin
      opnd_b = ex_mem_alu_result_q;
    end else if (wb_hit_b) begin
      opnd_b = bus.mem_wb_write_data;
    end
  end
`else
  // Without forwarding the register-file values are used as read
  always_comb begin
    opnd_a = bus.id_ex_readdat1;
    opnd_b = bus.id_ex_readdat2;
  end
`endif

  assign alu_b     = alu_src ? bus.id_ex_sign_ext : opnd_b;
  assign btgt      = bus.id_ex_npc + (bus.id_ex_sign_ext << 2);
  assign write_reg = reg_dst ? bus.id_ex_instr_bits_15_11 : bus.id_ex_instr_bits_20_16;

  // Single-cycle ALU; MULT yields zero here because its result comes from mul_iter
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = opnd_a + alu_b;
      ALU_SUB: alu_result = opnd_a - alu_b;
      ALU_AND: alu_result = opnd_a & alu_b;
      ALU_OR:  alu_result = opnd_a | alu_b;
      ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(opnd_a) < $signed(alu_b))};
      default: alu_result = '0;
    endcase
  end

  // start is only honoured in IDLE, so a MULT still held in ID/EX during DONE
  // does not relaunch the sequence
  mul_iter #(
    .DATA_W (DATA_W)
  ) u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (is_mult),
    .op_a    (opnd_a),
    .op_b    (alu_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Stall while a MULT waits to start or is iterating; released in DONE so
  // upstream advances on the same edge that captures the product
  assign stall        = (is_mult && !mul_busy && !mul_done) || mul_busy;
  assign bus.ex_stall = rst && stall;

  assign result_sel = mul_done ? mul_product : alu_result;

  // EX/MEM next value: bubble the control fields while stalled
  always_comb begin
    ex_mem_wb_d         = bus.id_ex_wb;
    ex_mem_m_d          = bus.id_ex_mem;
    ex_mem_btgt_d       = btgt;
    ex_mem_alu_result_d = result_sel;
    ex_mem_zero_d       = (result_sel == '0);
    ex_mem_rdata2_d     = opnd_b;
    ex_mem_write_reg_d  = write_reg;
    if (stall) begin
      ex_mem_wb_d = '0;
      ex_mem_m_d  = '0;
    end
  end

  // EX/MEM pipeline latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_mem_wb_q         <= '0;
      ex_mem_m_q          <= '0;
      ex_mem_btgt_q       <= '0;
      ex_mem_zero_q       <= 1'b0;
      ex_mem_alu_result_q <= '0;
      ex_mem_rdata2_q     <= '0;
      ex_mem_write_reg_q  <= '0;
    end else begin
      ex_mem_wb_q         <= ex_mem_wb_d;
      ex_mem_m_q          <= ex_mem_m_d;
      ex_mem_btgt_q       <= ex_mem_btgt_d;
      ex_mem_zero_q       <= ex_mem_zero_d;
      ex_mem_alu_result_q <= ex_mem_alu_result_d;
      ex_mem_rdata2_q     <= ex_mem_rdata2_d;
      ex_mem_write_reg_q  <= ex_mem_write_reg_d;
    end
  end

  assign bus.ex_mem_wb         = ex_mem_wb_q;
  assign bus.ex_mem_m          = ex_mem_m_q;
  assign bus.ex_mem_btgt       = ex_mem_btgt_q;
  assign bus.ex_mem_zero       = ex_mem_zero_q;
  assign bus.ex_mem_alu_result = ex_mem_alu_result_q;
  assign bus.ex_mem_rdata2     = ex_mem_rdata2_q;
  assign bus.ex_mem_write_reg  = ex_mem_write_reg_q;

endmodule

// File: tb/tb_execute.sv
// tb_execute: scoreboard bench for the EX stage. Each issued instruction's
// expected EX/MEM contents come from a behavioural model and are queued; a
// monitor pops and compares whenever EX/MEM carries a non-bubble.
module tb_execute;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  execute #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] btgt;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rdata2;
    logic [4:0]  wreg;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  // current instruction fields
  logic [1:0]  c_wb;
  logic [2:0]  c_m;
  logic        c_regdst;
  logic [1:0]  c_aluop;
  logic        c_alusrc;
  logic [31:0] c_npc, c_rd1, c_rd2, c_se;
  logic [4:0]  c_rt, c_rd;
`ifdef EXECUTE_FWD_EN
  logic [4:0]  c_rs;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        prev_we;
  logic [4:0]  prev_dest;
  logic [31:0] prev_res;

  // newest producer wins; r0 is hard-wired zero and never forwarded
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] raw);
    if (prev_we && prev_dest != 5'd0 && prev_dest == r) return prev_res;
    if (wb_we && wb_reg != 5'd0 && wb_reg == r) return wb_data;
    return raw;
  endfunction
`endif

  function automatic exp_t model();
    logic [31:0] a, bo, b, r;
    exp_t e;
`ifdef EXECUTE_FWD_EN
    a  = fwd(c_rs, c_rd1);
    bo = fwd(c_rt, c_rd2);
`else
    a  = c_rd1;
    bo = c_rd2;
`endif
    b = c_alusrc ? c_se : bo;
    case (c_aluop)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd3: r = a | b;
      default: begin
        case (c_se[5:0])
          6'h20:   r = a + b;
          6'h22:   r = a - b;
          6'h24:   r = a & b;
          6'h25:   r = a | b;
          6'h2A:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18:   r = a * b;
          default: r = 32'd0;
        endcase
      end
    endcase
    e.wb     = c_wb;
    e.m      = c_m;
    e.btgt   = c_npc + (c_se << 2);
    e.zero   = (r == 32'd0);
    e.alu    = r;
    e.rdata2 = bo;
    e.wreg   = c_regdst ? c_rd : c_rt;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive();
    bus.id_ex_wb               = c_wb;
    bus.id_ex_mem              = c_m;
    bus.id_ex_execute          = {c_regdst, c_aluop, c_alusrc};
    bus.id_ex_npc              = c_npc;
    bus.id_ex_readdat1         = c_rd1;
    bus.id_ex_readdat2         = c_rd2;
    bus.id_ex_sign_ext         = c_se;
    bus.id_ex_instr_bits_20_16 = c_rt;
    bus.id_ex_instr_bits_15_11 = c_rd;
`ifdef EXECUTE_FWD_EN
    bus.id_ex_instr_bits_25_21 = c_rs;
    bus.mem_wb_reg_write       = wb_we;
    bus.mem_wb_write_reg       = wb_reg;
    bus.mem_wb_write_data      = wb_data;
`endif
  endtask

  task automatic clear_c();
    c_wb = '0; c_m = '0; c_regdst = 1'b0; c_aluop = '0; c_alusrc = 1'b0;
    c_npc = '0; c_rd1 = '0; c_rd2 = '0; c_se = '0; c_rt = '0; c_rd = '0;
`ifdef EXECUTE_FWD_EN
    c_rs = '0; wb_we = 1'b0; wb_reg = '0; wb_data = '0;
`endif
  endtask

  task automatic flush_model();
`ifdef EXECUTE_FWD_EN
    prev_we = 1'b0; prev_dest = '0; prev_res = '0;
`endif
  endtask

  // Called at posedge+1: present the instruction, queue its expected result and
  // hold it until the stage stops stalling, then advance past the capture edge.
  task automatic issue();
    exp_t e;
    int   stalls;
    bit   bubbles_ok;
    bit   mul;
    stalls     = 0;
    bubbles_ok = 1'b1;
    mul        = (c_aluop == 2'd2) && (c_se[5:0] == 6'h18);
    e          = model();
    drive();
    exp_q.push_back(e);
`ifdef EXECUTE_FWD_EN
    prev_we   = c_wb[1];
    prev_dest = e.wreg;
    prev_res  = e.alu;
`endif
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.ex_stall) break;
      stalls++;
      if (stalls > 1 && (bus.ex_mem_wb != 2'd0 || bus.ex_mem_m != 3'd0)) bubbles_ok = 1'b0;
    end
    check(mul ? "mult_stall_cycles" : "no_stall", 128'(stalls), mul ? 128'd33 : 128'd0);
    if (mul) check("mult_bubbles", 128'(bubbles_ok), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue_idle();
    clear_c();
    drive();
    flush_model();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_instr();
    logic [5:0]  functs [7];
    logic [31:0] tmp;
    logic [5:0]  f;
    functs   = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h3F};
    c_wb     = 2'($urandom_range(1, 3));
    c_m      = 3'($urandom);
    c_regdst = 1'($urandom);
    c_aluop  = 2'($urandom);
    c_alusrc = 1'($urandom);
    c_npc    = $urandom & 32'hFFFF_FFFC;
    c_rd1    = $urandom;
    c_rd2    = ($urandom_range(0, 4) == 0) ? c_rd1 : $urandom;
    f        = functs[$urandom_range(0, 6)];
    if ($urandom_range(0, 7) == 0) begin
      c_aluop  = 2'd2;
      f        = 6'h18;
      c_alusrc = 1'b0;
    end
    tmp   = $urandom;
    c_se  = {tmp[31:6], f};
    c_rt  = 5'($urandom);
    c_rd  = 5'($urandom);
`ifdef EXECUTE_FWD_EN
    c_rs    = 5'($urandom_range(0, 3));
    c_rt    = 5'($urandom_range(0, 3));
    wb_we   = 1'($urandom);
    wb_reg  = 5'($urandom_range(0, 3));
    wb_data = $urandom;
`endif
  endtask

  // Scoreboard monitor: every non-bubble EX/MEM word must match the queue head
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst && (bus.ex_mem_wb != 2'd0 || bus.ex_mem_m != 3'd0)) begin
        got.wb     = bus.ex_mem_wb;
        got.m      = bus.ex_mem_m;
        got.btgt   = bus.ex_mem_btgt;
        got.zero   = bus.ex_mem_zero;
        got.alu    = bus.ex_mem_alu_result;
        got.rdata2 = bus.ex_mem_rdata2;
        got.wreg   = bus.ex_mem_write_reg;
        checks++;
        txn++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL exmem_unexpected txn=%0d alu=%h wb=%b m=%b", txn, got.alu, got.wb, got.m);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL exmem txn=%0d got wb=%b m=%b btgt=%h z=%b alu=%h rd2=%h wr=%0d want wb=%b m=%b btgt=%h z=%b alu=%h rd2=%h wr=%0d",
                     txn, got.wb, got.m, got.btgt, got.zero, got.alu, got.rdata2, got.wreg,
                     e.wb, e.m, e.btgt, e.zero, e.alu, e.rdata2, e.wreg);
          end else begin
            $display("txn %0d ok wb=%b m=%b alu=%h btgt=%h wr=%0d", txn, got.wb, got.m, got.alu, got.btgt, got.wreg);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_c();
    flush_model();
    drive();
    #2 rst = 1'b0;
    #1;
    check("reset_outputs",
          {bus.ex_stall, bus.ex_mem_wb, bus.ex_mem_m, bus.ex_mem_zero, bus.ex_mem_write_reg,
           bus.ex_mem_btgt, bus.ex_mem_alu_result, bus.ex_mem_rdata2}, 128'd0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // add 5+7 with RegWrite, then an asynchronous reset mid-cycle
    c_wb = 2'b10; c_rd1 = 32'd5; c_rd2 = 32'd7; c_rt = 5'd4;
    issue();
    clear_c();
    drive();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {bus.ex_stall, bus.ex_mem_wb, bus.ex_mem_m, bus.ex_mem_zero, bus.ex_mem_write_reg,
           bus.ex_mem_btgt, bus.ex_mem_alu_result, bus.ex_mem_rdata2}, 128'd0);
    #1 rst = 1'b1;
    flush_model();
    @(posedge clk);
    #1;

    // R-type add wrapping to zero, destination rd
    clear_c();
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h20;
    c_rd1 = 32'hFFFF_FFFF; c_rd2 = 32'd1; c_rt = 5'd2; c_rd = 5'd3;
    issue();

    // signed slt: most-negative < 1
    clear_c();
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h2A;
    c_rd1 = 32'h8000_0000; c_rd2 = 32'd1; c_rd = 5'd7;
    issue();

    // beq: equal operands, branch target npc + imm*4
    clear_c();
    c_m = 3'b100; c_aluop = 2'd1; c_rd1 = 32'd9; c_rd2 = 32'd9;
    c_npc = 32'h100; c_se = 32'd4;
    issue();

    // MULT held through its stall
    clear_c();
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h18;
    c_rd1 = 32'h12345; c_rd2 = 32'h1000; c_rd = 5'd10;
    issue();
    issue_idle();

    // reset pulse while the multiplier sits at count 10
    clear_c();
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h18;
    c_rd1 = 32'd3; c_rd2 = 32'd4; c_rd = 5'd11;
    drive();
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mult_stall", 128'(bus.ex_stall), 128'd0);
    check("rst_mid_mult_result", {bus.ex_mem_wb, bus.ex_mem_alu_result}, 128'd0);
    clear_c();
    drive();
    #1 rst = 1'b1;
    flush_model();
    @(posedge clk);
    #1;
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h18;
    c_rd1 = 32'd3; c_rd2 = 32'd4; c_rd = 5'd11;
    issue();
    issue_idle();

`ifdef EXECUTE_FWD_EN
    // EX/MEM forwarding: add r8 = 0x10 + 0x10, then add r9 = r8 + r8 with stale reads
    clear_c();
    c_wb = 2'b10; c_alusrc = 1'b1; c_rd1 = 32'h10; c_se = 32'h10; c_rt = 5'd8;
    issue();
    clear_c();
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h20;
    c_rs = 5'd8; c_rt = 5'd8; c_rd = 5'd9;
    issue();
    issue_idle();
    // MEM/WB-only forwarding
    clear_c();
    wb_we = 1'b1; wb_reg = 5'd8; wb_data = 32'h77;
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h20;
    c_rs = 5'd8; c_rt = 5'd8; c_rd = 5'd9;
    issue();
    issue_idle();
    // a write to r0 is never forwarded
    clear_c();
    c_wb = 2'b10; c_alusrc = 1'b1; c_rd1 = 32'h30; c_se = 32'h5; c_rt = 5'd0;
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hABCD;
    issue();
    clear_c();
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'hABCD;
    c_wb = 2'b10; c_regdst = 1'b1; c_aluop = 2'd2; c_se = 32'h20;
    c_rs = 5'd0; c_rt = 5'd0; c_rd1 = 32'd1; c_rd2 = 32'd2; c_rd = 5'd9;
    issue();
    issue_idle();
`endif

    // randomized instruction stream with occasional idle slots
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        issue_idle();
      end else begin
        randomize_instr();
        issue();
      end
    end
    issue_idle();
    issue_idle();
    @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
